// File: rtl/rv32_bus_arbiter_pkg.sv
// Shared types for the rv32 two-master bus arbiter.
// Fetch and data requests use the same record so one mux and one register cover both.
package rv32_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GRANT_INSTR = 2'd1,
    ST_GRANT_DATA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  mask;
    logic [31:0] value;
  } rv32_bus_req_t;

endpackage

// File: rtl/rv32_bus_arbiter_if.sv
// Core fetch bus, core data bus and shared memory bus around the arbiter.
// slave: the arbiter's view; master: the core plus memory driving it.
interface rv32_bus_arbiter_if;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;

  modport slave (
    input  instr_address_in, instr_read_in,
    output instr_read_value_out, instr_ready_out,
    input  data_address_in, data_read_in, data_write_in, data_write_mask_in, data_write_value_in,
    output data_read_value_out, data_ready_out,
    output address_out, read_out, write_out, write_mask_out, write_value_out,
    input  read_value_in, ready_in
  );

  modport master (
    output instr_address_in, instr_read_in,
    input  instr_read_value_out, instr_ready_out,
    output data_address_in, data_read_in, data_write_in, data_write_mask_in, data_write_value_in,
    input  data_read_value_out, data_ready_out,
    input  address_out, read_out, write_out, write_mask_out, write_value_out,
    output read_value_in, ready_in
  );
endinterface

// File: rtl/rv32_bus_arbiter_pick.sv
// Winner selection for the idle arbitration decision: data first, fetch otherwise.
// RV32_BUS_ARBITER_FAIRNESS_EN adds a saturating streak counter that forces a fetch through.
module rv32_bus_arbiter_pick #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ireq,
  input  logic dreq,
  input  logic grant_vld,
  output logic pick_vld,
  output logic pick_instr
);

  assign pick_vld = ireq | dreq;

`ifdef RV32_BUS_ARBITER_FAIRNESS_EN
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_d, streak_q;
  logic          force_instr;

  assign force_instr = (streak_q == STREAK_MAX);
  assign pick_instr  = ireq & (~dreq | force_instr);

  // Only contended data wins count; any fetch grant restarts the streak.
  always_comb begin
    streak_d = streak_q;
    if (grant_vld) begin
      if (pick_instr) begin
        streak_d = '0;
      end else if (ireq && !force_instr) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  logic unused_pick;

  assign pick_instr  = ireq & ~dreq;
  assign unused_pick = clk ^ reset ^ grant_vld ^ (MAX_DATA_STREAK > 0);
`endif

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Merges the rv32 fetch and data buses onto one shared memory bus, zero added latency in IDLE.
// Optional fetch starvation guard: RV32_BUS_ARBITER_FAIRNESS_EN.
module rv32_bus_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  rv32_bus_arbiter_if.slave bus
);

  arb_state_e    state_d, state_q;
  rv32_bus_req_t req_d, req_q;
  rv32_bus_req_t instr_req, data_req, bus_req, bus_out;
  logic          abandoned_d, abandoned_q;
  logic          ireq, dreq;
  logic          pick_vld, pick_instr, grant_vld;
  logic          owner_vld, owner_instr;

  assign ireq      = bus.instr_read_in;
  assign dreq      = bus.data_read_in | bus.data_write_in;
  assign grant_vld = (state_q == ST_IDLE) & pick_vld;

  assign instr_req = '{address: bus.instr_address_in, read: ireq, write: 1'b0,
                       mask: 4'h0, value: 32'h0};
  assign data_req  = '{address: bus.data_address_in, read: bus.data_read_in,
                       write: bus.data_write_in, mask: bus.data_write_mask_in,
                       value: bus.data_write_value_in};

  rv32_bus_arbiter_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .dreq      (dreq),
    .grant_vld (grant_vld),
    .pick_vld  (pick_vld),
    .pick_instr(pick_instr)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    abandoned_d = abandoned_q;
    bus_req     = '0;
    owner_vld   = 1'b0;
    owner_instr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abandoned_d = 1'b0;
        if (pick_vld) begin
          owner_vld   = 1'b1;
          owner_instr = pick_instr;
          bus_req     = pick_instr ? instr_req : data_req;
          // Only park the request if the slave did not finish it this cycle.
          if (!bus.ready_in) begin
            req_d   = bus_req;
            state_d = pick_instr ? ST_GRANT_INSTR : ST_GRANT_DATA;
          end
        end
      end
      ST_GRANT_INSTR, ST_GRANT_DATA: begin
        owner_vld   = 1'b1;
        owner_instr = (state_q == ST_GRANT_INSTR);
        bus_req     = req_q;
        if (owner_instr ? !ireq : !dreq) begin
          abandoned_d = 1'b1;
        end
        if (bus.ready_in) begin
          state_d     = ST_IDLE;
          abandoned_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      abandoned_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      abandoned_q <= abandoned_d;
    end
  end

  // Reset gates the outputs combinationally so the slave sees silence at once.
  assign bus_out             = reset ? bus_req : '0;
  assign bus.address_out     = bus_out.address;
  assign bus.read_out        = bus_out.read;
  assign bus.write_out       = bus_out.write;
  assign bus.write_mask_out  = bus_out.mask;
  assign bus.write_value_out = bus_out.value;

  assign bus.instr_ready_out = reset & bus.ready_in & owner_vld & owner_instr
                             & ireq & ~abandoned_q;
  assign bus.data_ready_out  = reset & bus.ready_in & owner_vld & ~owner_instr
                             & dreq & ~abandoned_q;

  assign bus.instr_read_value_out = bus.read_value_in;
  assign bus.data_read_value_out  = bus.read_value_in;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed scoreboard bench for rv32_bus_arbiter: stimulus queues expected bus cycles, a monitor checks them.
module tb_rv32_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv32_bus_arbiter_if bus();

  rv32_bus_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wval;
    logic        iry;
    logic        dry;
    logic [31:0] rval;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rval_drv = 32'h0;

  task automatic drv_i(input logic r, input logic [31:0] a);
    bus.instr_read_in    = r;
    bus.instr_address_in = a;
  endtask

  task automatic drv_d(input logic r, input logic w, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] v);
    bus.data_read_in        = r;
    bus.data_write_in       = w;
    bus.data_write_mask_in  = m;
    bus.data_address_in     = a;
    bus.data_write_value_in = v;
  endtask

  task automatic drv_m(input logic rdy, input logic [31:0] rv);
    bus.ready_in      = rdy;
    bus.read_value_in = rv;
    rval_drv          = rv;
  endtask

  // Queue the expected response for the cycle just driven, then advance one cycle.
  task automatic expect_cyc(input string nm, input logic [31:0] a, input logic rd,
                            input logic wr, input logic [3:0] m, input logic [31:0] v,
                            input logic iry, input logic dry);
    exp_t e;
    e.nm = nm; e.addr = a; e.rd = rd; e.wr = wr; e.mask = m; e.wval = v;
    e.iry = iry; e.dry = dry; e.rval = rval_drv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.address_out !== e.addr || bus.read_out !== e.rd || bus.write_out !== e.wr ||
          bus.write_mask_out !== e.mask || bus.write_value_out !== e.wval ||
          bus.instr_ready_out !== e.iry || bus.data_ready_out !== e.dry ||
          bus.instr_read_value_out !== e.rval || bus.data_read_value_out !== e.rval) begin
        n_errors++;
        $display("FAIL %s: got addr=%h rd=%b wr=%b mask=%h wval=%h irdy=%b drdy=%b irv=%h drv=%h; want addr=%h rd=%b wr=%b mask=%h wval=%h irdy=%b drdy=%b rv=%h",
                 e.nm, bus.address_out, bus.read_out, bus.write_out, bus.write_mask_out,
                 bus.write_value_out, bus.instr_ready_out, bus.data_ready_out,
                 bus.instr_read_value_out, bus.data_read_value_out,
                 e.addr, e.rd, e.wr, e.mask, e.wval, e.iry, e.dry, e.rval);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic is_i;
    drv_i(1'b1, 32'h40);
    drv_d(1'b0, 1'b1, 4'hF, 32'h44, 32'h1234);
    drv_m(1'b1, 32'h99);
    @(posedge clk);
    #1;
    expect_cyc("reset_outputs", 32'h0, 0, 0, 4'h0, 32'h0, 0, 0);

    reset = 1'b1;
    drv_i(1'b0, 32'h0);
    drv_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_m(1'b1, 32'h0);
    expect_cyc("idle_ready_ignored", 32'h0, 0, 0, 4'h0, 32'h0, 0, 0);

    drv_d(1'b0, 1'b1, 4'b0011, 32'h1000, 32'hDEADBEEF);
    expect_cyc("data_write_same_cycle", 32'h1000, 0, 1, 4'b0011, 32'hDEADBEEF, 0, 1);
    drv_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_i(1'b1, 32'h80);
    drv_m(1'b1, 32'h13);
    expect_cyc("fetch_after_write", 32'h80, 1, 0, 4'h0, 32'h0, 1, 0);
    drv_i(1'b0, 32'h0);
    drv_d(1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
    drv_m(1'b1, 32'hCAFE);
    expect_cyc("data_read_same_cycle", 32'h2000, 1, 0, 4'hF, 32'h0, 0, 1);

    drv_i(1'b1, 32'h100);
    drv_d(1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
    drv_m(1'b0, 32'h0);
    expect_cyc("contend_c1", 32'h3000, 1, 0, 4'hF, 32'h0, 0, 0);
    drv_i(1'b1, 32'h104);
    drv_d(1'b1, 1'b0, 4'hF, 32'h3004, 32'h0);
    expect_cyc("contend_c2_hold", 32'h3000, 1, 0, 4'hF, 32'h0, 0, 0);
    drv_i(1'b1, 32'h108);
    expect_cyc("contend_c3_hold", 32'h3000, 1, 0, 4'hF, 32'h0, 0, 0);
    drv_m(1'b1, 32'h55);
    expect_cyc("contend_c4_done", 32'h3000, 1, 0, 4'hF, 32'h0, 0, 1);
    drv_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_m(1'b1, 32'h66);
    expect_cyc("contend_fetch_next", 32'h108, 1, 0, 4'h0, 32'h0, 1, 0);
    drv_i(1'b0, 32'h0);
    drv_m(1'b0, 32'h0);
    expect_cyc("idle_after_contend", 32'h0, 0, 0, 4'h0, 32'h0, 0, 0);

    drv_i(1'b1, 32'h200);
    expect_cyc("abandon_c1", 32'h200, 1, 0, 4'h0, 32'h0, 0, 0);
    drv_i(1'b0, 32'h0);
    expect_cyc("abandon_c2_drop", 32'h200, 1, 0, 4'h0, 32'h0, 0, 0);
    drv_i(1'b1, 32'h300);
    expect_cyc("abandon_c3_reraise", 32'h200, 1, 0, 4'h0, 32'h0, 0, 0);
    drv_m(1'b1, 32'h71);
    expect_cyc("abandon_c4_swallow", 32'h200, 1, 0, 4'h0, 32'h0, 0, 0);
    drv_m(1'b1, 32'h72);
    expect_cyc("abandon_c5_new_fetch", 32'h300, 1, 0, 4'h0, 32'h0, 1, 0);
    drv_i(1'b0, 32'h0);
    drv_m(1'b0, 32'h0);
    expect_cyc("idle_after_abandon", 32'h0, 0, 0, 4'h0, 32'h0, 0, 0);

    drv_i(1'b1, 32'h400);
    drv_d(1'b1, 1'b0, 4'h0, 32'h500, 32'h0);
    drv_m(1'b1, 32'h5A);
    for (int k = 0; k < 10; k++) begin
`ifdef RV32_BUS_ARBITER_FAIRNESS_EN
      is_i = (k == 4) || (k == 9);
`else
      is_i = 1'b0;
`endif
      if (is_i) begin
        expect_cyc($sformatf("fair_%0d_instr", k), 32'h400, 1, 0, 4'h0, 32'h0, 1, 0);
      end else begin
        expect_cyc($sformatf("fair_%0d_data", k), 32'h500, 1, 0, 4'h0, 32'h0, 0, 1);
      end
    end
    drv_i(1'b0, 32'h0);
    drv_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_m(1'b0, 32'h0);
    expect_cyc("idle_after_fair", 32'h0, 0, 0, 4'h0, 32'h0, 0, 0);

    drv_d(1'b0, 1'b1, 4'hF, 32'h600, 32'hA5A5A5A5);
    expect_cyc("rst_mid_c1", 32'h600, 0, 1, 4'hF, 32'hA5A5A5A5, 0, 0);
    expect_cyc("rst_mid_c2_grant", 32'h600, 0, 1, 4'hF, 32'hA5A5A5A5, 0, 0);
    reset = 1'b0;
    drv_i(1'b1, 32'h700);
    drv_m(1'b1, 32'h77);
    expect_cyc("rst_mid_forced_zero", 32'h0, 0, 0, 4'h0, 32'h0, 0, 0);
    reset = 1'b1;
    drv_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drv_m(1'b0, 32'h0);
    expect_cyc("rst_release_fresh", 32'h700, 1, 0, 4'h0, 32'h0, 0, 0);
    drv_m(1'b1, 32'h88);
    expect_cyc("rst_release_done", 32'h700, 1, 0, 4'h0, 32'h0, 1, 0);
    drv_i(1'b0, 32'h0);
    drv_m(1'b0, 32'h0);
    expect_cyc("idle_final", 32'h0, 0, 0, 4'h0, 32'h0, 0, 0);

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
